// File: rtl/systolic_mac_array_pkg.sv
// Shared types and sizing helpers for the systolic MAC array.
//   state_t      : top-level job FSM states
//   acc_width()  : accumulator width for a given operand width / matrix size
//   feed_beats() : skewed input beats per job (2*SIZE-1)
//   total_beats(): grid advances per job including zero flush (3*SIZE-2)
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // A full-scale product needs 2*width bits; summing size of them adds clog2(size).
  function automatic int acc_width(input int width, input int size);
    return 2 * width + $clog2(size);
  endfunction

  function automatic int feed_beats(input int size);
    return 2 * size - 1;
  endfunction

  function automatic int total_beats(input int size);
    return 3 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// Job/stream bundle between the systolic MAC array and its upstream deskew
// stage plus downstream result sink.
//   start, busy, done               : job control / status
//   a_skew, b_skew, in_valid/ready  : skewed operand beats (SIZE lanes of WIDTH)
//   out_row, out_valid/ready, last  : drained C rows (SIZE lanes of ACC_W)
// Modports: master = driver of the block, slave = the array itself.
interface systolic_mac_array_if
  import systolic_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
);
  localparam int ACC_W = acc_width(WIDTH, SIZE);

  logic                    start;
  logic [SIZE*WIDTH-1:0]   a_skew;
  logic [SIZE*WIDTH-1:0]   b_skew;
  logic                    in_valid;
  logic                    in_ready;
  logic [SIZE*ACC_W-1:0]   out_row;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;
  logic                    done;

  modport master (
    output start, a_skew, b_skew, in_valid, out_ready,
    input  in_ready, out_row, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, a_skew, b_skew, in_valid, out_ready,
    output in_ready, out_row, out_valid, out_last, busy, done
  );

endinterface

// File: rtl/systolic_mac_array_pe.sv
// One output-stationary MAC cell of the systolic grid.
//   clock, reset : rising-edge clock, async active-high reset
//   clear        : synchronous zero of accumulator and pass registers (job start)
//   en           : grid advance; when low the cell holds everything
//   a_in / a_out : A operand in from the left, registered copy out to the right
//   b_in / b_out : B operand in from above, registered copy out below
//   acc          : running dot-product for this C element
// Build option: SYSMM_SIGNED_EN selects a two's-complement multiply with
// sign-extended accumulate; otherwise everything is unsigned.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] prod_ext;

`ifdef SYSMM_SIGNED_EN
  logic signed [2*WIDTH-1:0] a_x, b_x, prod;
  assign a_x      = (2*WIDTH)'($signed(a_in));
  assign b_x      = (2*WIDTH)'($signed(b_in));
  assign prod     = a_x * b_x;
  // Size cast of a signed value sign-extends; the adder below is width-exact,
  // so two's-complement wrap in the bit pattern is the signed sum.
  assign prod_ext = ACC_W'(prod);
`else
  logic [2*WIDTH-1:0] prod;
  assign prod     = (2*WIDTH)'(a_in) * (2*WIDTH)'(b_in);
  assign prod_ext = ACC_W'(prod);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (clear) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      acc   <= acc + prod_ext;
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary SIZE x SIZE systolic MAC grid computing C = A x B.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : start/busy/done job control, skewed A/B beat stream in,
//                  C rows out one per handshake (see systolic_mac_array_if)
// A job: start in IDLE clears the grid; COMPUTE takes 2*SIZE-1 skewed beats,
// then injects SIZE-1 zero beats to flush the wavefront; DRAIN presents C row
// by row. Build option SYSMM_SIGNED_EN switches the PEs to signed arithmetic.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  systolic_mac_array_if.slave  bus
);

  localparam int ACC_W = acc_width(WIDTH, SIZE);
  localparam int FEED  = feed_beats(SIZE);
  localparam int TOTAL = total_beats(SIZE);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [CNT_W-1:0] FEED_CNT  = CNT_W'(FEED);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(SIZE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt;
  logic [ROW_W-1:0] row_cnt;

  logic feeding, advance, clear;
  logic in_ready, out_valid, out_last, done;

  assign feeding = (beat_cnt < FEED_CNT);

  // ---------------- FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    advance   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        in_ready = feeding;
        // Flush beats advance unconditionally; feed beats wait for data.
        advance  = (bus.in_valid & feeding) | ~feeding;
        if (advance && beat_cnt == LAST_BEAT) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (row_cnt == LAST_ROW);
        if (bus.out_ready && out_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- counters ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      if (clear)        beat_cnt <= '0;
      else if (advance) beat_cnt <= beat_cnt + 1'b1;

      if (clear)
        row_cnt <= '0;
      else if (out_valid && bus.out_ready)
        row_cnt <= out_last ? '0 : row_cnt + 1'b1;
    end
  end

  // ---------------- grid ----------------
  // a_h[i][j] is the A operand entering PE(i,j); b_v[i][j] the B operand.
  // The extra column/row catches the outputs of the last PEs, which leave the grid.
  logic [WIDTH-1:0] a_h [SIZE][SIZE+1];
  logic [WIDTH-1:0] b_v [SIZE+1][SIZE];
  logic [ACC_W-1:0] acc [SIZE][SIZE];

  genvar gi, gj;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_edge
      assign a_h[gi][0] = feeding ? bus.a_skew[gi*WIDTH +: WIDTH] : '0;
      assign b_v[0][gi] = feeding ? bus.b_skew[gi*WIDTH +: WIDTH] : '0;
    end

    for (gi = 0; gi < SIZE; gi++) begin : g_row
      for (gj = 0; gj < SIZE; gj++) begin : g_col
        systolic_pe #(
          .WIDTH (WIDTH),
          .ACC_W (ACC_W)
        ) u_pe (
          .clock (clock),
          .reset (reset),
          .clear (clear),
          .en    (advance),
          .a_in  (a_h[gi][gj]),
          .b_in  (b_v[gi][gj]),
          .a_out (a_h[gi][gj+1]),
          .b_out (b_v[gi+1][gj]),
          .acc   (acc[gi][gj])
        );
      end
    end
  endgenerate

  // ---------------- drain mux ----------------
  logic [SIZE*ACC_W-1:0] out_row;

  always_comb begin
    out_row = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < SIZE; j++)
        out_row[j*ACC_W +: ACC_W] = acc[row_cnt][j];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_row   = out_row;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done;

endmodule
